// File: rtl/rp_count_capture.sv
// Consumer side of the reconfigurable counter partition: captures the counter nibbles onto the
// LED bus, freezes them across a DFX decouple window, and tracks stalls and value changes.
module rp_count_capture #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STALL_CYCLES  = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic [3:0]       upper_in,
  input  logic [3:0]       lower_in,
  input  logic             decouple_req,
  output logic             decouple_ack,
  output logic [7:0]       led,
  output logic             rp_active,
  output logic             stall,
  output logic [CNT_W-1:0] change_count
);

  localparam int unsigned StallW  = $clog2(STALL_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StHold, StSettle} state_e;

  state_e             state_q, state_d;
  logic [7:0]         held_q, held_d;
  logic               ack_q, ack_d;
  logic               active_q, active_d;
  logic               stall_q, stall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [StallW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;

  logic [7:0] sample;
  assign sample = {upper_in, lower_in};

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    ack_d        = ack_q;
    active_d     = active_q;
    stall_d      = stall_q;
    cnt_d        = cnt_q;
    stall_cnt_d  = stall_cnt_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      StRun: begin
        if (decouple_req) begin
          // Isolation wins over any capture on this edge.
          state_d  = StHold;
          ack_d    = 1'b1;
          active_d = 1'b0;
        end else if (sample != held_q) begin
          held_d      = sample;
          stall_cnt_d = '0;
          stall_d     = 1'b0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
          if (stall_cnt_q != StallW'(STALL_CYCLES)) stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_d == StallW'(STALL_CYCLES)) stall_d = 1'b1;
        end
      end
      StHold: begin
        if (!decouple_req) begin
          state_d      = StSettle;
          ack_d        = 1'b0;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        if (decouple_req) begin
          state_d = StHold;
          ack_d   = 1'b1;
        end else if (settle_cnt_q == SettleW'(SETTLE_CYCLES - 1)) begin
          // Last settle edge: capture restarts on the next edge with a fresh stall window.
          state_d     = StRun;
          active_d    = 1'b1;
          stall_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StRun;
        active_d = 1'b1;
        ack_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q      <= StRun;
      held_q       <= '0;
      ack_q        <= 1'b0;
      active_q     <= 1'b1;
      stall_q      <= 1'b0;
      cnt_q        <= '0;
      stall_cnt_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      ack_q        <= ack_d;
      active_q     <= active_d;
      stall_q      <= stall_d;
      cnt_q        <= cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign led          = held_q;
  assign decouple_ack = ack_q;
  assign rp_active    = active_q;
  assign stall        = stall_q;
  assign change_count = cnt_q;

endmodule
